param_frame_tx: RTL and testbench
=================================

// Module: param_frame_tx
// PURPOSE
// - Serialises a fixed parameter set onto the 1-bit line feeding the pass-through cell: integer, sized integer, real, string.
// - Checksummed frame. Exercises every parameter kind (integer, sized/truncated, string, real) through synthesis and round-trip.
// - Sequencer for that cell's single-bit input: start/busy/done handshake, optional abort.
// PARAMETERS
// - PARAM_INTEGER        10           32-bit field, sent MSB first
// - PARAM_INTEGER_SIZED  [7:0] 65535  8-bit field; truncation to 8'hFF is intended and must survive
// - PARAM_REAL           3.14         sent as 32-bit $rtoi(PARAM_REAL*1000) (3140 = 32'h00000C44)
// - PARAM_STRING         "A string."  STR_LEN bytes, first character first
// - STR_LEN              9            string field length in bytes; shorter strings are left-padded with 8'h00
// - CLK_DIV              4            clocks per bit (>=1)
// PORTS
// - clk        in   1  rising-edge clock
// - rst        in   1  synchronous, active-high reset
// - start      in   1  request frame; accepted only when busy==0
// - abort      in   1  cancel the frame in progress
// - busy       out  1  frame in progress
// - done       out  1  one-cycle pulse after the last bit period completes
// - sdo        out  1  serial data; 0 when idle
// - sdo_valid  out  1  high while sdo carries a frame bit
// BEHAVIOUR
// - Reset: busy=0, done=0, sdo=0, sdo_valid=0, FSM=IDLE, all counters and the checksum cleared.
// - Frame, MSB first per byte:
//   - SYNC 8'hA5
//   - INT 32 bits
//   - SIZED 8 bits
//   - REAL 32 bits
//   - STR 8*STR_LEN bits
//   - CSUM 8 bits
//   - Total 88+8*STR_LEN bits (160 at defaults).
// - String byte i (i=0 first) = PARAM_STRING[8*(STR_LEN-i)-1 -: 8].
// - CSUM = running XOR of every payload byte (INT, SIZED, REAL, STR; not SYNC). It is accumulated as bytes are sent, not precomputed. Defaults give 8'hE7.
// - FSM: IDLE -> SYNC -> INT -> SIZED -> REAL -> STR -> CSUM -> IDLE. Each state lasts (field bits)*CLK_DIV cycles.
// - Latency: start high in IDLE at edge N gives busy=1, sdo_valid=1 and sdo=bit7 of 8'hA5 from N+1.
//   - Each bit is held exactly CLK_DIV cycles.
//   - busy stays high for (88+8*STR_LEN)*CLK_DIV cycles.
// - On the cycle after the last CSUM bit period: done=1 for one cycle, busy=0, sdo_valid=0, sdo=0.
//   - A start in that same cycle is accepted: back-to-back frames with no idle gap beyond the done cycle.
// - start while busy: ignored; no queuing.
// - abort while busy: next cycle IDLE, busy=0, sdo=0, sdo_valid=0, no done, checksum cleared.
//   - abort while idle: no effect. abort and start together in IDLE: abort wins and the frame is not started.
// - rst mid-frame: identical to the reset state on the next cycle; no done pulse.
// - Divider wrap: the bit advances when div_cnt==CLK_DIV-1. CLK_DIV=1 means one bit per cycle with no dead cycles.
// - Counters sized $clog2 of their maximum. The byte counter spans STR_LEN bytes without overflow.
// STRUCTURE
// - Shared defs file param_frame_defs.vh:
//   - state encodings (IDLE..CSUM)
//   - SYNC_BYTE=8'hA5
//   - field widths 32/8/32/8
//   - REAL_SCALE=1000
// - One sub-module, param_frame_shifter:
//   - 8-bit load/shift register plus CLK_DIV bit-period divider
//   - outputs bit_tick and byte_done
// - The top holds the FSM, field mux, byte index and XOR checksum.
// TESTING
// - Defaults, CLK_DIV=4, pulse start: capture 160 bits, 640 busy cycles. Bytes:
//   - A5 00 00 00 0A FF 00 00 0C 44 41 20 73 74 72 69 6E 67 2E E7
//   - then a single done pulse.
// - PARAM_INTEGER_SIZED=300, CLK_DIV=1: SIZED byte = 8'h2C; checksum matches the recomputed XOR; 160 busy cycles.
// - PARAM_STRING="AB", STR_LEN=4: STR bytes 00 00 41 42; frame is 120 bits.
// - start re-pulsed at bit 50: ignored, frame unchanged. start on the done cycle: second frame identical, next cycle onward.
// - abort at cycle 100: next cycle busy=0, sdo=0, no done. Fresh start then yields the full correct frame with CSUM E7.
// - rst asserted at cycle 37 mid-INT: all outputs at reset values next cycle. A new frame afterwards is bit-exact.

Source files
------------

// File: rtl/param_frame_pkg.sv
// Shared definitions for the parameter frame transmitter.
// Field states, sync byte, field widths and the real-value scale.
package param_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_INT,
        ST_SIZED,
        ST_REAL,
        ST_STR,
        ST_CSUM
    } state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         INT_W      = 32;
    localparam int         SIZED_W    = 8;
    localparam int         REAL_W     = 32;
    localparam int         CSUM_W     = 8;
    localparam int         REAL_SCALE = 1000;

    function automatic state_t next_field(input state_t s);
        unique case (s)
            ST_SYNC:  return ST_INT;
            ST_INT:   return ST_SIZED;
            ST_SIZED: return ST_REAL;
            ST_REAL:  return ST_STR;
            ST_STR:   return ST_CSUM;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/param_frame_shifter.sv
// Byte load/shift register with a CLK_DIV bit-period divider.
// bit_tick marks the last cycle of a bit, byte_done the last cycle of a byte.
module param_frame_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] din,
    output logic       sdo,
    output logic       bit_tick,
    output logic       byte_done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sr;

    assign bit_tick  = en && (div_cnt == DW'(CLK_DIV - 1));
    assign byte_done = bit_tick && (bit_cnt == 3'd7);
    assign sdo       = sr[7];

    // A load on the byte_done cycle takes priority over the final shift.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sr      <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= din;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (bit_tick) begin
            sr      <= {sr[6:0], 1'b0};
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 3'd1;
        end else if (en) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/param_frame_tx.sv
// Serialises SYNC, integer, sized, real, string and XOR checksum fields
// MSB first onto a single line with a start/busy/done handshake.
module param_frame_tx
    import param_frame_pkg::*;
#(
    parameter int                   PARAM_INTEGER       = 10,
    parameter int                   PARAM_INTEGER_SIZED = 65535,
    parameter real                  PARAM_REAL          = 3.14,
    parameter int                   STR_LEN             = 9,
    parameter logic [8*STR_LEN-1:0] PARAM_STRING        = "A string.",
    parameter int                   CLK_DIV             = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    output logic sdo,
    output logic sdo_valid
);

    localparam logic [INT_W-1:0]   INT_V   = INT_W'(PARAM_INTEGER);
    localparam logic [SIZED_W-1:0] SIZED_V = SIZED_W'(PARAM_INTEGER_SIZED);
    localparam logic [REAL_W-1:0]  REAL_V  =
        REAL_W'($rtoi(PARAM_REAL * REAL_SCALE));
    localparam int MAXB = (STR_LEN > INT_W / 8) ? STR_LEN : INT_W / 8;
    localparam int IW   = (MAXB > 1) ? $clog2(MAXB) : 1;

    state_t            state;
    state_t            ns;
    logic [IW-1:0]     byte_idx;
    logic [IW-1:0]     ni;
    logic [IW-1:0]     last_idx;
    logic [CSUM_W-1:0] csum;
    logic [7:0]        nxt_byte;
    logic              load;
    logic              clear;
    logic              frame_end;
    logic              bit_tick;
    logic              byte_done;
    logic              payload;

    always_comb begin
        last_idx = '0;
        unique case (state)
            ST_INT:   last_idx = IW'(INT_W / 8 - 1);
            ST_SIZED: last_idx = IW'(SIZED_W / 8 - 1);
            ST_REAL:  last_idx = IW'(REAL_W / 8 - 1);
            ST_STR:   last_idx = IW'(STR_LEN - 1);
            default:  last_idx = '0;
        endcase
    end

    always_comb begin
        ns = state;
        ni = byte_idx;
        if (state == ST_IDLE) begin
            if (start) begin
                ns = ST_SYNC;
                ni = '0;
            end
        end else if (byte_done) begin
            if (byte_idx == last_idx) begin
                ns = next_field(state);
                ni = '0;
            end else begin
                ni = byte_idx + 1'b1;
            end
        end
    end

    // Byte to load for the field/index being entered.
    always_comb begin
        nxt_byte = '0;
        unique case (ns)
            ST_SYNC:  nxt_byte = SYNC_BYTE;
            ST_INT:   nxt_byte = 8'(INT_V >> (8 * (INT_W / 8 - 1 - int'(ni))));
            ST_SIZED: nxt_byte = SIZED_V;
            ST_REAL:  nxt_byte = 8'(REAL_V >> (8 * (REAL_W / 8 - 1 - int'(ni))));
            ST_STR:   nxt_byte = 8'(PARAM_STRING >> (8 * (STR_LEN - 1 - int'(ni))));
            ST_CSUM:  nxt_byte = csum;
            default:  nxt_byte = '0;
        endcase
    end

    assign frame_end = (state == ST_CSUM) && byte_done;
    assign load      = !abort &&
                       (((state == ST_IDLE) && start) || (byte_done && !frame_end));
    assign clear     = abort || frame_end;
    assign payload   = (ns == ST_INT) || (ns == ST_SIZED) ||
                       (ns == ST_REAL) || (ns == ST_STR);

    // Checksum folds in each payload byte as it is loaded for sending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            byte_idx  <= '0;
            csum      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sdo_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                byte_idx  <= '0;
                csum      <= '0;
                busy      <= 1'b0;
                sdo_valid <= 1'b0;
            end else begin
                state    <= ns;
                byte_idx <= ni;
                if ((state == ST_IDLE) && start) begin
                    busy      <= 1'b1;
                    sdo_valid <= 1'b1;
                    csum      <= '0;
                end else if (frame_end) begin
                    busy      <= 1'b0;
                    sdo_valid <= 1'b0;
                    done      <= 1'b1;
                    csum      <= '0;
                end else if (load && payload) begin
                    csum <= csum ^ nxt_byte;
                end
            end
        end
    end

    param_frame_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .load     (load),
        .en       (busy),
        .din      (nxt_byte),
        .sdo      (sdo),
        .bit_tick (bit_tick),
        .byte_done(byte_done)
    );

endmodule

// File: tb/tb_param_frame_tx.sv
// Bench for param_frame_tx: default instance (CLK_DIV=4) and a
// CLK_DIV=1 instance with a truncated sized value and a short padded string.
module tb_param_frame_tx;

    logic       clk;
    logic       rst;
    logic [1:0] start_s;
    logic [1:0] abort_s;
    logic [1:0] busy_s;
    logic [1:0] done_s;
    logic [1:0] sdo_s;
    logic [1:0] vld_s;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] frame0[20];

    typedef struct {
        int u;
        int ev;
        int ev_at;
        int exp_len;
        bit exp_done;
    } row_t;

    row_t rows[9];

    int         ph[2];
    int         nb[2];
    logic [7:0] sh[2];
    logic       cur[2];

    param_frame_tx u0 (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s[0]),
        .abort    (abort_s[0]),
        .busy     (busy_s[0]),
        .done     (done_s[0]),
        .sdo      (sdo_s[0]),
        .sdo_valid(vld_s[0])
    );

    param_frame_tx #(
        .PARAM_INTEGER_SIZED(300),
        .STR_LEN            (4),
        .PARAM_STRING       (32'h0000_4142),
        .CLK_DIV            (1)
    ) u1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s[1]),
        .abort    (abort_s[1]),
        .busy     (busy_s[1]),
        .done     (done_s[1]),
        .sdo      (sdo_s[1]),
        .sdo_valid(vld_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int div_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    // Independent model of the u1 frame, including the checksum.
    task automatic push_model();
        logic [7:0]  b[$];
        logic [7:0]  x;
        logic [31:0] iv;
        logic [31:0] rv;
        logic [31:0] sv;
        logic [31:0] big;
        iv  = 32'd10;
        rv  = 32'd3140;
        sv  = 32'h0000_4142;
        big = 32'd300;
        for (int i = 0; i < 4; i++) b.push_back(iv[8*(3-i) +: 8]);
        b.push_back(big[7:0]);
        for (int i = 0; i < 4; i++) b.push_back(rv[8*(3-i) +: 8]);
        for (int i = 0; i < 4; i++) b.push_back(sv[8*(3-i) +: 8]);
        x = 8'h00;
        foreach (b[i]) x ^= b[i];
        q1.push_back(8'hA5);
        foreach (b[i]) q1.push_back(b[i]);
        q1.push_back(x);
    endtask

    task automatic push_exp(input int u);
        if (u == 0) begin
            foreach (frame0[i]) q0.push_back(frame0[i]);
        end else begin
            push_model();
        end
    endtask

    // Bit capture at the first cycle of each bit period; bytes are popped
    // from the scoreboard as they complete.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (vld_s[u]) begin
                if (ph[u] == 0) begin
                    cur[u] = sdo_s[u];
                    sh[u]  = {sh[u][6:0], sdo_s[u]};
                    nb[u]++;
                    if (nb[u] == 8) begin
                        nb[u] = 0;
                        if ((u == 0 ? q0.size() : q1.size()) == 0) begin
                            check($sformatf("u%0d_sb_underflow", u), 1, 0);
                        end else if (u == 0) begin
                            check("u0_byte", sh[u], q0.pop_front());
                        end else begin
                            check("u1_byte", sh[u], q1.pop_front());
                        end
                    end
                end else begin
                    check($sformatf("u%0d_hold", u), sdo_s[u], cur[u]);
                end
                ph[u] = (ph[u] + 1 == div_of(u)) ? 0 : ph[u] + 1;
            end else begin
                ph[u] = 0;
                nb[u] = 0;
            end
        end
    end

    // Called at a negedge; raises start immediately.
    task automatic run_frame(input int id, input row_t r);
        int k;
        int u;
        u = r.u;
        start_s[u] = 1'b1;
        @(negedge clk);
        start_s[u] = 1'b0;
        check($sformatf("row%0d_lat", id),
              {busy_s[u], vld_s[u], sdo_s[u]}, 3'b111);
        k = 1;
        while (busy_s[u] && k <= 4000) begin
            if (k == r.ev_at) begin
                case (r.ev)
                    1: start_s[u] = 1'b1;
                    2: abort_s[u] = 1'b1;
                    3: rst = 1'b1;
                    default: ;
                endcase
            end
            @(negedge clk);
            start_s[u] = 1'b0;
            abort_s[u] = 1'b0;
            rst        = 1'b0;
            if (busy_s[u]) k++;
        end
        check($sformatf("row%0d_busy_len", id), k, r.exp_len);
        check($sformatf("row%0d_end", id),
              {done_s[u], vld_s[u], sdo_s[u]}, {r.exp_done, 2'b00});
        @(negedge clk);
        check($sformatf("row%0d_done_pulse", id), done_s[u], 1'b0);
        if (r.ev == 0 || r.ev == 1) begin
            check($sformatf("row%0d_sb_drain", id),
                  (u == 0) ? q0.size() : q1.size(), 0);
        end
        if (u == 0) q0.delete();
        else q1.delete();
    endtask

    initial begin
        int k;
        rst     = 1'b1;
        start_s = '0;
        abort_s = '0;
        ph      = '{0, 0};
        nb      = '{0, 0};
        frame0  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hFF, 8'h00,
                    8'h00, 8'h0C, 8'h44, 8'h41, 8'h20, 8'h73, 8'h74,
                    8'h72, 8'h69, 8'h6E, 8'h67, 8'h2E, 8'hE7};
        rows[0] = '{0, 0, 0,   640, 1'b1};
        rows[1] = '{0, 1, 200, 640, 1'b1};
        rows[2] = '{0, 2, 100, 100, 1'b0};
        rows[3] = '{0, 0, 0,   640, 1'b1};
        rows[4] = '{0, 3, 37,  37,  1'b0};
        rows[5] = '{0, 0, 0,   640, 1'b1};
        rows[6] = '{1, 0, 0,   120, 1'b1};
        rows[7] = '{1, 2, 30,  30,  1'b0};
        rows[8] = '{1, 0, 0,   120, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_u0", {busy_s[0], done_s[0], sdo_s[0], vld_s[0]}, 4'b0000);
        check("rst_u1", {busy_s[1], done_s[1], sdo_s[1], vld_s[1]}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            push_exp(rows[i].u);
            run_frame(i, rows[i]);
            @(negedge clk);
        end

        // abort and start together while idle: abort wins
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        check("start_abort_idle", {busy_s[0], vld_s[0], sdo_s[0]}, 3'b000);
        @(negedge clk);
        check("start_abort_idle2", {busy_s[0], done_s[0]}, 2'b00);

        // back-to-back: second start on the done cycle
        push_exp(0);
        push_exp(0);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        k = 0;
        while (!done_s[0] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("b2b_done_seen", done_s[0], 1'b1);
        check("b2b_first_len", k, 640);
        run_frame(99, rows[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
